fv_req_bus: RTL and testbench
=============================

FV_REQ_BUS -- requirements
Module: fv_req_bus

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of Edge PE request ports (power of 2, >=2).
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of FV SRAM banks (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_W, default 10, global FV address width; BW=log2(NUM_BANKS), TW=log2(NUM_PE).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 pe_req_valid  input  NUM_PE  per-PE FV read request valid.
REQ-007 pe_req_addr  input  NUM_PE*ADDR_W  per-PE global FV address.
REQ-008 pe_req_ready  output  NUM_PE  per-PE holding slot empty; request accepted when valid&&ready.
REQ-009 bank_req_valid  output  NUM_BANKS  per-bank request valid to FV bank controller.
REQ-010 bank_req_addr  output  NUM_BANKS*(ADDR_W-BW)  bank-local address = global addr[ADDR_W-1:BW].
REQ-011 bank_req_pe_tag  output  NUM_BANKS*TW  index of requesting PE, returned by bank with FV data.
REQ-012 bank_ready  input  NUM_BANKS  bank controller accepts request when valid&&ready.

Function
REQ-013 SHALL hold one request per PE in a holding slot (addr, held flag); pe_req_ready = !held, registered, no combinational path from any input.
REQ-014 SHALL ignore pe_req_valid while pe_req_ready is low; PE keeps request until accepted.
REQ-015 SHALL decode target bank of a held request as addr[BW-1:0].
REQ-016 SHALL run one round-robin arbiter per bank over held slots targeting that bank; priority starts at PE (last_grant+1) mod NUM_PE.
REQ-017 SHALL grant a bank only when its output register is empty or being drained this cycle (bank_req_valid && bank_ready).
REQ-018 On grant: load output register (valid, local addr, PE tag), clear granted slot's held flag, set bank's last_grant to granted PE.
REQ-019 SHALL leave last_grant unchanged in cycles without grant for that bank.
REQ-020 Latency: request accepted in cycle N -> held at N+1 -> earliest bank_req_valid at N+2; earliest new acceptance on same PE at N+2.
REQ-021 SHALL hold bank_req_valid/addr/pe_tag stable while bank_req_valid && !bank_ready.
REQ-022 Drain and grant in same cycle SHALL give back-to-back valid requests (100% bank throughput under contention).
REQ-023 Different banks SHALL arbitrate independently; NUM_BANKS grants per cycle possible.
REQ-024 Each PE SHALL receive at most one grant per cycle (one slot, one target bank).

Reset
REQ-025 On reset low at a clock edge: all held flags 0, all bank_req_valid 0, bank_req_addr/pe_tag 0, all last_grant = NUM_PE-1 (PE 0 highest priority first); pe_req_ready all 1 from the following cycle.
REQ-026 Reset mid-operation SHALL discard held and in-flight requests without emitting them.

Configuration
REQ-027 With FV_REQ_BUS_STALL_CNT_EN defined: output stall_cnt (NUM_PE*16) counts per-PE cycles with held && !granted, saturating at 16'hFFFF, cleared by reset.
REQ-028 Without FV_REQ_BUS_STALL_CNT_EN: port stall_cnt and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold request struct (valid, addr, PE_tag) and NUM_PE/NUM_BANKS/ADDR_W defaults alongside existing Num_Edge_PE/Num_Banks_FV.
REQ-030 Per-bank arbiter SHALL be sub-module fv_rr_arbiter (req vector, last_grant in, grant one-hot out, combinational); instantiated NUM_BANKS times.

Verification
REQ-031 Single: PE1 addr 0x025 at cycle 0, bank_ready=1 -> cycle 2 bank_req_valid[1]=1, addr 0x009, tag 1; pe_req_ready[1] high at cycle 2.
REQ-032 Contention: PEs 0-3 all target bank 2 same cycle, bank_ready=1 -> bank 2 issues tags 0,1,2,3 on consecutive cycles starting cycle 2.
REQ-033 Backpressure: bank_ready[0]=0 for 5 cycles with request pending -> output stable 5 cycles, single transfer when ready rises, no duplicate.
REQ-034 Parallel: PEs 0-3 target banks 3,2,1,0 -> all four bank_req_valid high in cycle 2.
REQ-035 Reset mid-op: assert reset with 3 held requests -> next cycle all bank_req_valid 0, pe_req_ready all 1, none of the 3 requests ever emitted.
REQ-036 With FV_REQ_BUS_STALL_CNT_EN: bank_ready[0]=0 for 10 cycles with PE0 held -> stall_cnt[0]=10.

Source files
------------

// File: rtl/fv_req_bus_pkg.sv
// Shared FV request-bus types and default sizing for the Edge PE -> FV SRAM bank request path.
package fv_req_bus_pkg;

    localparam int Num_Edge_PE  = 4;
    localparam int Num_Banks_FV = 4;

    localparam int FV_NUM_PE    = Num_Edge_PE;
    localparam int FV_NUM_BANKS = Num_Banks_FV;
    localparam int FV_ADDR_W    = 10;
    localparam int FV_TAG_W     = $clog2(FV_NUM_PE);

    typedef struct packed {
        logic                 valid;
        logic [FV_ADDR_W-1:0] addr;
        logic [FV_TAG_W-1:0]  pe_tag;
    } fv_req_t;

endpackage

// File: rtl/fv_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position past last_grant and wraps.
module fv_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant
);

    localparam int TW = $clog2(N);

    logic [TW-1:0] idx;
    logic          found;

    // N is a power of two, so the TW-bit add wraps exactly like mod N.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = last_grant + TW'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fv_req_bus.sv
// FV request bus: per-PE holding slots feeding per-bank round-robin arbiters and output registers.
// Optional per-PE stall counters are built when FV_REQ_BUS_STALL_CNT_EN is defined.
module fv_req_bus
    import fv_req_bus_pkg::*;
#(
    parameter int NUM_PE    = FV_NUM_PE,
    parameter int NUM_BANKS = FV_NUM_BANKS,
    parameter int ADDR_W    = FV_ADDR_W
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_PE-1:0]                              pe_req_valid,
    input  logic [NUM_PE*ADDR_W-1:0]                       pe_req_addr,
    output logic [NUM_PE-1:0]                              pe_req_ready,
    output logic [NUM_BANKS-1:0]                           bank_req_valid,
    output logic [NUM_BANKS*(ADDR_W-$clog2(NUM_BANKS))-1:0] bank_req_addr,
    output logic [NUM_BANKS*$clog2(NUM_PE)-1:0]            bank_req_pe_tag,
`ifdef FV_REQ_BUS_STALL_CNT_EN
    output logic [NUM_PE*16-1:0]                           stall_cnt,
`endif
    input  logic [NUM_BANKS-1:0]                           bank_ready
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int TW = $clog2(NUM_PE);
    localparam int LW = ADDR_W - BW;

    logic [NUM_PE-1:0] vld_p0;
    logic [ADDR_W-1:0] addr_p0 [NUM_PE];
    logic [NUM_PE-1:0] accept;
    logic [NUM_PE-1:0] pe_granted;

    logic [NUM_PE-1:0] breq    [NUM_BANKS];
    logic [NUM_PE-1:0] gnt_raw [NUM_BANKS];
    logic [NUM_PE-1:0] gnt     [NUM_BANKS];
    logic [TW-1:0]     gnt_idx [NUM_BANKS];
    logic [TW-1:0]     last_grant [NUM_BANKS];
    logic [NUM_BANKS-1:0] grant_en;
    logic [NUM_BANKS-1:0] bank_load;

    logic [NUM_BANKS-1:0] vld_p1;
    logic [LW-1:0]        addr_p1 [NUM_BANKS];
    logic [TW-1:0]        tag_p1  [NUM_BANKS];

    // Stage p0: per-PE holding slot; ready is the registered empty flag only.
    assign pe_req_ready = ~vld_p0;
    assign accept       = pe_req_valid & ~vld_p0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0 <= '0;
        end else begin
            vld_p0 <= (vld_p0 & ~pe_granted) | accept;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PE; p++) begin
            if (accept[p]) begin
                addr_p0[p] <= pe_req_addr[p*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            grant_en[b] = !vld_p1[b] || bank_ready[b];
            breq[b]     = '0;
            for (int p = 0; p < NUM_PE; p++) begin
                breq[b][p] = vld_p0[p] && (addr_p0[p][BW-1:0] == BW'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_arb
        fv_rr_arbiter #(
            .N (NUM_PE)
        ) u_arb (
            .req        (breq[gb]),
            .last_grant (last_grant[gb]),
            .grant      (gnt_raw[gb])
        );
    end

    // A PE decodes to exactly one bank, so OR-ing the bank grants cannot double-grant a slot.
    always_comb begin
        pe_granted = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt[b]       = gnt_raw[b] & {NUM_PE{grant_en[b]}};
            bank_load[b] = |gnt[b];
            gnt_idx[b]   = '0;
            for (int p = 0; p < NUM_PE; p++) begin
                if (gnt_raw[b][p]) begin
                    gnt_idx[b] = TW'(p);
                end
            end
            pe_granted = pe_granted | gnt[b];
        end
    end

    // Stage p1: per-bank output register, reloaded in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                addr_p1[b]    <= '0;
                tag_p1[b]     <= '0;
                last_grant[b] <= TW'(NUM_PE - 1);
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_load[b]) begin
                    vld_p1[b]     <= 1'b1;
                    addr_p1[b]    <= addr_p0[gnt_idx[b]][ADDR_W-1:BW];
                    tag_p1[b]     <= gnt_idx[b];
                    last_grant[b] <= gnt_idx[b];
                end else if (bank_ready[b]) begin
                    vld_p1[b] <= 1'b0;
                end
            end
        end
    end

    assign bank_req_valid = vld_p1;

    always_comb begin
        bank_req_addr   = '0;
        bank_req_pe_tag = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req_addr[b*LW +: LW]   = addr_p1[b];
            bank_req_pe_tag[b*TW +: TW] = tag_p1[b];
        end
    end

`ifdef FV_REQ_BUS_STALL_CNT_EN
    logic [15:0] stall_q [NUM_PE];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PE; p++) begin
                stall_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (vld_p0[p] && !pe_granted[p]) begin
                    stall_q[p] <= sat_inc16(stall_q[p]);
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            stall_cnt[p*16 +: 16] = stall_q[p];
        end
    end
`endif

endmodule

// File: tb/tb_fv_req_bus.sv
// Self-checking bench for fv_req_bus: directed scenarios plus random traffic against a transaction-level model.
module tb_fv_req_bus;

    localparam int NUM_PE    = 4;
    localparam int NUM_BANKS = 4;
    localparam int ADDR_W    = 10;
    localparam int BW        = 2;
    localparam int TW        = 2;
    localparam int LW        = ADDR_W - BW;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_PE-1:0]             pe_req_valid;
    logic [NUM_PE*ADDR_W-1:0]      pe_req_addr;
    logic [NUM_PE-1:0]             pe_req_ready;
    logic [NUM_BANKS-1:0]          bank_req_valid;
    logic [NUM_BANKS*LW-1:0]       bank_req_addr;
    logic [NUM_BANKS*TW-1:0]       bank_req_pe_tag;
    logic [NUM_BANKS-1:0]          bank_ready;
`ifdef FV_REQ_BUS_STALL_CNT_EN
    logic [NUM_PE*16-1:0]          stall_cnt;
`endif

    always #5 clk = ~clk;

    fv_req_bus #(
        .NUM_PE    (NUM_PE),
        .NUM_BANKS (NUM_BANKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pe_req_valid    (pe_req_valid),
        .pe_req_addr     (pe_req_addr),
        .pe_req_ready    (pe_req_ready),
        .bank_req_valid  (bank_req_valid),
        .bank_req_addr   (bank_req_addr),
        .bank_req_pe_tag (bank_req_pe_tag),
`ifdef FV_REQ_BUS_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .bank_ready      (bank_ready)
    );

    int vectors     = 0;
    int miscompares = 0;
    int xfer0       = 0;
    int valid_seen  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending request per PE, one outstanding request per bank.
    bit m_held [NUM_PE];
    int m_addr [NUM_PE];
    bit m_ov   [NUM_BANKS];
    int m_oaddr[NUM_BANKS];
    int m_otag [NUM_BANKS];
    int m_last [NUM_BANKS];
    int m_stall[NUM_PE];

    task automatic m_clear();
        for (int p = 0; p < NUM_PE; p++) begin
            m_held[p]  = 0;
            m_addr[p]  = 0;
            m_stall[p] = 0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            m_ov[b]    = 0;
            m_oaddr[b] = 0;
            m_otag[b]  = 0;
            m_last[b]  = NUM_PE - 1;
        end
    endtask

    task automatic m_advance();
        bit acc [NUM_PE];
        bit gnt [NUM_PE];
        int winner;
        int p;
        if (!reset) begin
            m_clear();
            return;
        end
        for (int q = 0; q < NUM_PE; q++) begin
            acc[q] = !m_held[q] && pe_req_valid[q];
            gnt[q] = 0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            winner = -1;
            if (!m_ov[b] || bank_ready[b]) begin
                for (int k = 1; k <= NUM_PE; k++) begin
                    p = (m_last[b] + k) % NUM_PE;
                    if (winner < 0 && m_held[p] && (m_addr[p] % NUM_BANKS) == b) winner = p;
                end
            end
            if (winner >= 0) begin
                m_ov[b]     = 1;
                m_oaddr[b]  = m_addr[winner] / NUM_BANKS;
                m_otag[b]   = winner;
                m_last[b]   = winner;
                gnt[winner] = 1;
            end else if (m_ov[b] && bank_ready[b]) begin
                m_ov[b] = 0;
            end
        end
        for (int q = 0; q < NUM_PE; q++) begin
            if (m_held[q] && !gnt[q] && m_stall[q] < 65535) m_stall[q]++;
            if (gnt[q]) m_held[q] = 0;
            if (acc[q]) begin
                m_held[q] = 1;
                m_addr[q] = int'(pe_req_addr[q*ADDR_W +: ADDR_W]);
            end
        end
    endtask

    task automatic sample();
        logic [NUM_PE-1:0]    e_rdy;
        logic [NUM_BANKS-1:0] e_vld;
        logic [NUM_BANKS*LW-1:0] e_addr;
        logic [NUM_BANKS*TW-1:0] e_tag;
        @(negedge clk);
        for (int p = 0; p < NUM_PE; p++) e_rdy[p] = !m_held[p];
        for (int b = 0; b < NUM_BANKS; b++) begin
            e_vld[b]            = m_ov[b];
            e_addr[b*LW +: LW]  = LW'(m_oaddr[b]);
            e_tag[b*TW +: TW]   = TW'(m_otag[b]);
        end
        check_eq("ready",     64'(pe_req_ready),    64'(e_rdy));
        check_eq("bank_vld",  64'(bank_req_valid),  64'(e_vld));
        check_eq("bank_addr", 64'(bank_req_addr),   64'(e_addr));
        check_eq("bank_tag",  64'(bank_req_pe_tag), 64'(e_tag));
`ifdef FV_REQ_BUS_STALL_CNT_EN
        check_eq("stall0", 64'(stall_cnt[15:0]), 64'(m_stall[0]));
`endif
        if (bank_req_valid[0] && bank_ready[0]) xfer0++;
        if (|bank_req_valid) valid_seen++;
    endtask

    task automatic advance();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic idle();
        pe_req_valid = '0;
        pe_req_addr  = '0;
    endtask

    task automatic set_req(input int p, input int a);
        pe_req_valid[p] = 1'b1;
        pe_req_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    initial begin
        reset      = 1'b0;
        bank_ready = '1;
        idle();
        @(posedge clk);
        #1;
        m_clear();
        sample();
        check_eq("rst_ready", 64'(pe_req_ready), 64'hF);
        check_eq("rst_valid", 64'(bank_req_valid), 64'h0);
        advance();
        reset = 1'b1;
        tick(1);

        // Single request: PE1 -> bank 1, local 0x009, tag 1 two cycles later.
        set_req(1, 'h025);
        tick(1);
        idle();
        tick(1);
        sample();
        check_eq("single_vld",  64'(bank_req_valid), 64'b0010);
        check_eq("single_addr", 64'(bank_req_addr[1*LW +: LW]), 64'h009);
        check_eq("single_tag",  64'(bank_req_pe_tag[1*TW +: TW]), 64'd1);
        check_eq("single_rdy",  64'(pe_req_ready[1]), 64'd1);
        advance();
        tick(2);

        // Contention: all PEs hit bank 2; tags come out 0,1,2,3 back to back.
        for (int p = 0; p < NUM_PE; p++) set_req(p, 'h002 + 4 * p);
        tick(1);
        idle();
        tick(1);
        for (int i = 0; i < NUM_PE; i++) begin
            sample();
            check_eq("contend_vld",  64'(bank_req_valid[2]), 64'd1);
            check_eq("contend_tag",  64'(bank_req_pe_tag[2*TW +: TW]), 64'(i));
            check_eq("contend_addr", 64'(bank_req_addr[2*LW +: LW]), 64'(i));
            advance();
        end
        tick(2);

        // Backpressure on bank 0 for five cycles, then exactly one transfer.
        xfer0      = 0;
        bank_ready = 4'b1110;
        set_req(0, 'h010);
        tick(1);
        idle();
        tick(1);
        for (int i = 0; i < 5; i++) begin
            sample();
            check_eq("bp_vld",  64'(bank_req_valid[0]), 64'd1);
            check_eq("bp_addr", 64'(bank_req_addr[0 +: LW]), 64'h004);
            check_eq("bp_tag",  64'(bank_req_pe_tag[0 +: TW]), 64'd0);
            advance();
        end
        bank_ready = '1;
        tick(1);
        sample();
        check_eq("bp_drained", 64'(bank_req_valid[0]), 64'd0);
        check_eq("bp_xfers",   64'(xfer0), 64'd1);
        advance();
        tick(1);

        // Parallel: PEs 0..3 target banks 3..0, all banks valid together.
        for (int p = 0; p < NUM_PE; p++) set_req(p, (3 - p) + (p << 4));
        tick(1);
        idle();
        tick(1);
        sample();
        check_eq("par_vld", 64'(bank_req_valid), 64'hF);
        advance();
        tick(2);

        // Reset with three requests held behind a stalled bank 0.
        bank_ready = '0;
        set_req(0, 'h000);
        tick(1);
        idle();
        tick(1);
        set_req(1, 'h004);
        set_req(2, 'h008);
        set_req(3, 'h00C);
        tick(1);
        idle();
        sample();
        check_eq("held3_rdy", 64'(pe_req_ready), 64'b0001);
        advance();
        tick(1);
        reset = 1'b0;
        tick(1);
        reset      = 1'b1;
        bank_ready = '1;
        valid_seen = 0;
        sample();
        check_eq("rstmid_vld", 64'(bank_req_valid), 64'h0);
        check_eq("rstmid_rdy", 64'(pe_req_ready), 64'hF);
        advance();
        tick(6);
        check_eq("rstmid_none", 64'(valid_seen), 64'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            pe_req_valid = NUM_PE'($urandom);
            for (int p = 0; p < NUM_PE; p++) pe_req_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            bank_ready = NUM_BANKS'($urandom);
            reset      = ($urandom_range(0, 199) != 0);
            tick(1);
        end
        reset = 1'b1;
        idle();
        bank_ready = '1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
